// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a byte-wide register port with auto-incrementing pointer.
// Bus is oversampled by CLK_SYS; SDA is open-drain, SCL is never driven.
module i2c_slave_regs #(
    parameter logic [7:0] I2C_SLAVE_ADDR = 8'h72
) (
    input  logic       CLK_SYS,
    input  logic       RST,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_q, sda_q;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ph_q, ph_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic       last_bit, addr_match;
    logic [7:0] byte_in;

    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign byte_in   = {shift_q[6:0], sda_s};
    assign last_bit  = (cnt_q == 4'd7);
    assign addr_match = (byte_in[7:1] == I2C_SLAVE_ADDR[7:1]);

    assign I2C_SDA = oe_q ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus a third stage for edge detection
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], I2C_SCL};
            sda_q <= {sda_q[1:0], I2C_SDA};
        end
    end

    // State register
    always_ff @(posedge CLK_SYS) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; START/STOP override every state
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = DEV_ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:     state_d = IDLE;
                DEV_ADDR: if (scl_rise && last_bit)
                              state_d = addr_match ? DEV_ACK : IGNORE;
                DEV_ACK:  if (scl_fall && ph_q)
                              state_d = rw_q ? RD_DATA : REG_ADDR;
                REG_ADDR: if (scl_rise && last_bit) state_d = REG_ACK;
                REG_ACK:  if (scl_fall && ph_q) state_d = WR_DATA;
                WR_DATA:  if (scl_rise && last_bit) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && ph_q) state_d = WR_DATA;
                RD_DATA:  if (scl_fall && cnt_q == 4'd8) state_d = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && !ph_q && sda_s) state_d = IGNORE;
                    else if (scl_fall && ph_q)      state_d = RD_DATA;
                end
                IGNORE:   state_d = IGNORE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next-state: shifting, ACK drive, register strobes
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (we_q) addr_d = addr_q + 8'd1;
        if (start_det) begin
            cnt_d = 4'd0;
            ph_d  = 1'b0;
            oe_d  = 1'b0;
        end else if (stop_det) begin
            cnt_d  = 4'd0;
            ph_d   = 1'b0;
            oe_d   = 1'b0;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (last_bit) begin
                            cnt_d = 4'd0;
                            ph_d  = 1'b0;
                            if (state_q == DEV_ADDR) begin
                                rw_d   = byte_in[0];
                                busy_d = addr_match;
                            end
                            if (state_q == REG_ADDR) addr_d = byte_in;
                            if (state_q == WR_DATA) begin
                                wdata_d = byte_in;
                                we_d    = 1'b1;
                            end
                        end
                    end
                end
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            oe_d = 1'b1;
                            ph_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            ph_d  = 1'b0;
                            cnt_d = 4'd0;
                            if (state_q == DEV_ACK && rw_q) begin
                                shift_d = reg_rdata;
                                oe_d    = ~reg_rdata[7];
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                            ph_d  = 1'b0;
                        end else begin
                            shift_d = {shift_q[6:0], shift_q[7]};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !ph_q) begin
                        if (sda_s) begin
                            busy_d = 1'b0;
                        end else begin
                            ph_d   = 1'b1;
                            addr_d = addr_q + 8'd1;
                        end
                    end else if (scl_fall && ph_q) begin
                        ph_d    = 1'b0;
                        cnt_d   = 4'd0;
                        shift_d = reg_rdata;
                        oe_d    = ~reg_rdata[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            shift_q <= 8'h00;
            cnt_q   <= 4'd0;
            ph_q    <= 1'b0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master, register-file model
// and a queue-based scoreboard for ACKs, read bytes and write strobes.
module tb_i2c_slave_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, scl, m_low;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_regs #(.I2C_SLAVE_ADDR(8'h72)) dut (
        .CLK_SYS(clk), .RST(rst), .I2C_SCL(scl), .I2C_SDA(sda),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    // Register file seen by the DUT
    logic [7:0] mem [256];
    logic       init_go;
    logic [7:0] init_a, init_d;
    assign reg_rdata = mem[reg_addr];
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        else if (init_go) mem[init_a] <= init_d;
    end

    // Reference model: register contents and pointer
    logic [7:0] mdl [256];
    logic [7:0] ptr;

    int n_chk = 0;
    int n_fail = 0;
    int half = 5;
    int qtr = 2;

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_wr_q[$];
    wr_t        e;
    bit         exp_ack_q[$], got_ack_q[$];
    logic [7:0] exp_rd_q[$], got_rd_q[$];
    logic [7:0] wq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // Monitor: drains scoreboard queues and checks write strobes
    logic       we_prev = 1'b0;
    logic [7:0] addr_prev, addr_nx;
    bit         watch = 0;
    int         low_cnt, busy_cnt;
    always @(negedge clk) begin
        while (exp_ack_q.size() > 0 && got_ack_q.size() > 0)
            chk("ack", got_ack_q.pop_front(), exp_ack_q.pop_front());
        while (exp_rd_q.size() > 0 && got_rd_q.size() > 0)
            chk("rd_byte", got_rd_q.pop_front(), exp_rd_q.pop_front());
        if (reg_we === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_we: addr %0h data %0h", reg_addr, reg_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                chk("we_addr", reg_addr, e.a);
                chk("we_data", reg_wdata, e.d);
            end
        end
        if (we_prev) begin
            addr_nx = addr_prev + 8'd1;
            chk("we_width", reg_we, 0);
            chk("addr_inc", reg_addr, addr_nx);
        end
        we_prev   = (reg_we === 1'b1);
        addr_prev = reg_addr;
        if (watch && !m_low && sda === 1'b0) low_cnt++;
        if (watch && busy === 1'b1) busy_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        cyc(qtr); m_low = ~b;
        cyc(half - qtr); scl = 1'b1;
        cyc(half); scl = 1'b0;
    endtask

    task automatic recv_bit(output bit r);
        cyc(qtr); m_low = 1'b0;
        cyc(half - qtr); scl = 1'b1;
        cyc(half - 1); r = sda;
        cyc(1); scl = 1'b0;
    endtask

    task automatic start_c();
        cyc(half); m_low = 1'b1;
        cyc(half); scl = 1'b0;
    endtask

    task automatic rstart();
        cyc(qtr); m_low = 1'b0;
        cyc(half - qtr); scl = 1'b1;
        cyc(half); m_low = 1'b1;
        cyc(half); scl = 1'b0;
    endtask

    task automatic stop_c();
        cyc(qtr); m_low = 1'b1;
        cyc(half - qtr); scl = 1'b1;
        cyc(half); m_low = 1'b0;
        cyc(half);
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit want);
        bit a;
        exp_ack_q.push_back(want);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        got_ack_q.push_back(a);
    endtask

    task automatic rd_byte(input logic [7:0] want, input bit nack);
        bit         b;
        logic [7:0] v;
        exp_rd_q.push_back(want);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        got_rd_q.push_back(v);
        send_bit(nack);
    endtask

    // Write transaction: device byte, pointer byte, then the bytes in wq
    task automatic txn_write(input logic [7:0] dev, input logic [7:0] ra);
        bit match;
        match = (dev[7:1] == 7'h39) && !dev[0];
        start_c();
        wr_byte(dev, !match);
        if (match) chk("busy_set", busy, 1);
        wr_byte(ra, !match);
        if (match) ptr = ra;
        foreach (wq[i]) begin
            if (match) begin
                exp_wr_q.push_back('{ptr, wq[i]});
                mdl[ptr] = wq[i];
                ptr++;
            end
            wr_byte(wq[i], !match);
        end
        stop_c();
        cyc(2);
        chk("ptr_after_wr", reg_addr, ptr);
        chk("busy_after_stop", busy, 0);
    endtask

    task automatic txn_read(input logic [7:0] ra, input int n);
        start_c();
        wr_byte(8'h72, 1'b0);
        wr_byte(ra, 1'b0);
        ptr = ra;
        rstart();
        wr_byte(8'h73, 1'b0);
        for (int i = 0; i < n; i++) begin
            rd_byte(mdl[ptr], i == n - 1);
            if (i != n - 1) ptr++;
        end
        chk("busy_after_nack", busy, 0);
        stop_c();
        cyc(2);
        chk("ptr_after_rd", reg_addr, ptr);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        logic [7:0] dev;
        rst = 1'b1; scl = 1'b1; m_low = 1'b0; init_go = 1'b0;
        init_a = 8'h00; init_d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            init_a = i[7:0];
            init_d = (i == 8'h40) ? 8'h3C : (i == 8'h41) ? 8'hC3 : 8'($urandom);
            mdl[i] = init_d;
            init_go = 1'b1;
            cyc(1);
        end
        init_go = 1'b0;
        cyc(2);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sda", sda, 1);
        rst = 1'b0;
        ptr = 8'h00;
        cyc(4);

        // Single write
        wq = '{8'hA5};
        txn_write(8'h72, 8'h15);
        chk("wdata_after_wr", reg_wdata, 8'hA5);

        // Burst with pointer wrap
        wq = '{8'h11, 8'h22, 8'h33};
        txn_write(8'h72, 8'hFE);

        // Read with repeated START, ACK then NACK
        txn_read(8'h40, 2);

        // Address mismatch
        low_cnt = 0; busy_cnt = 0; watch = 1;
        wq = '{8'h99};
        txn_write(8'h74, 8'h15);
        watch = 0;
        chk("mismatch_sda_low", low_cnt, 0);
        chk("mismatch_busy", busy_cnt, 0);

        // STOP after 4 data bits
        start_c();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'h15, 1'b0);
        ptr = 8'h15;
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        stop_c();
        cyc(2);
        chk("abort_ptr", reg_addr, ptr);
        chk("abort_busy", busy, 0);

        // Reset while the device ACK is on the bus
        start_c();
        for (int i = 7; i >= 0; i--) send_bit(k == 0 ? 8'h72 >> i : 0);
        cyc(qtr); m_low = 1'b0;
        k = 0;
        while (sda !== 1'b0 && k < 20) begin
            cyc(1);
            k++;
        end
        chk("ack_before_rst", sda, 0);
        rst = 1'b1;
        cyc(1);
        chk("rst_sda_release", sda, 1);
        chk("rst_mid_addr", reg_addr, 0);
        rst = 1'b0;
        ptr = 8'h00;
        cyc(half); scl = 1'b1;
        cyc(half); scl = 1'b0;
        stop_c();
        cyc(2);
        chk("rst_mid_busy", busy, 0);

        // CLK_SYS/SCL = 100
        half = 50; qtr = 25;
        wq = '{8'h5A};
        txn_write(8'h72, 8'h15);
        txn_read(8'h15, 2);
        half = 5; qtr = 2;

        // Randomized transactions at ratios 10 and 20
        for (int t = 0; t < 24; t++) begin
            half = ($urandom_range(0, 1) == 0) ? 5 : 10;
            qtr = half / 2;
            case ($urandom_range(0, 2))
                0: begin
                    wq.delete();
                    for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                        wq.push_back(8'($urandom));
                    txn_write(8'h72, 8'($urandom));
                end
                1: txn_read(8'($urandom), int'($urandom_range(1, 3)));
                default: begin
                    dev = 8'($urandom);
                    if (dev[7:1] == 7'h39) dev[1] = ~dev[1];
                    wq = '{8'($urandom)};
                    txn_write(dev, 8'($urandom));
                end
            endcase
        end

        cyc(10);
        chk("wr_q_drained", exp_wr_q.size(), 0);
        chk("ack_q_drained", exp_ack_q.size() + got_ack_q.size(), 0);
        chk("rd_q_drained", exp_rd_q.size() + got_rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter I2C_SLAVE_ADDR, default 8'h72, which is the 8-bit write-form device address; only bits [7:1] are compared.
REQ-002 SHALL have port CLK_SYS, input, 1 bit: the single system clock, at least 10x the SCL frequency.
REQ-003 SHALL have port RST, input, 1 bit: reset that is synchronous and active-high.
REQ-004 SHALL have port I2C_SCL, input, 1 bit: bus clock from the master.
REQ-005 SHALL have port I2C_SDA, inout, 1 bit: open-drain data line, driven 1'b0 when the internal sda_oe is set, 1'bz otherwise.
REQ-006 SHALL have port reg_addr, output, 8 bits: register pointer.
REQ-007 SHALL have port reg_wdata, output, 8 bits: received write byte.
REQ-008 SHALL have port reg_we, output, 1 bit: one-cycle write strobe.
REQ-009 SHALL have port reg_rdata, input, 8 bits: read data for reg_addr, sampled when a read byte is loaded.
REQ-010 SHALL have port busy, output, 1 bit: high from an address match until STOP or NACK-terminated read.

Function
REQ-011 SHALL pass I2C_SCL and I2C_SDA through 2-flop synchronizers and use only the synchronized versions; edges are detected against a third registered copy.
REQ-012 SHALL detect START as a synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1, in any state.
REQ-013 SHALL sample SDA on SCL rising edges and change sda_oe only on SCL falling edges.
REQ-014 SHALL use FSM states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and IGNORE.
REQ-015 In IDLE, a START SHALL go to DEV_ADDR with the bit counter cleared; STOP in any state SHALL go to IDLE with sda_oe=0 and busy=0.
REQ-016 A START seen outside IDLE (repeated START) SHALL go to DEV_ADDR and keep reg_addr.
REQ-017 DEV_ADDR SHALL shift in 8 bits MSB first; on a match of [7:1] it goes to DEV_ACK, on a mismatch to IGNORE with SDA released.
REQ-018 IGNORE SHALL never drive SDA and leaves only on START or STOP.
REQ-019 Any ACK state SHALL drive sda_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-020 After DEV_ACK: if R/W=0, go to REG_ADDR; if R/W=1, load the shift register from reg_rdata and go to RD_DATA.
REQ-021 REG_ADDR SHALL load reg_addr with the received byte at the 8th rising edge, then go through REG_ACK to WR_DATA.
REQ-022 WR_DATA SHALL, at the 8th rising edge, set reg_wdata and pulse reg_we for exactly one CLK_SYS cycle in the next cycle; reg_addr SHALL increment one cycle after reg_we, then go through WR_ACK back to WR_DATA.
REQ-023 RD_DATA SHALL drive sda_oe = ~shift[7] MSB first, changing after each SCL falling edge, and release SDA after the 8th bit.
REQ-024 RD_ACK SHALL sample the master's ACK on the SCL rising edge: on ACK=0, increment reg_addr, reload from reg_rdata and continue RD_DATA; on NACK=1, go to IGNORE with busy=0.
REQ-025 reg_addr SHALL be 8-bit modulo, wrapping 8'hFF -> 8'h00 on increment.
REQ-026 The block SHALL never hold SCL low (no clock stretching) and SHALL never drive SDA high.
REQ-027 A START or STOP arriving mid-byte SHALL abort the byte: no reg_we, and reg_addr unchanged by the partial byte.

Reset
REQ-028 While RST=1 at a CLK_SYS rising edge, the block SHALL set state=IDLE, sda_oe=0 (SDA=z), reg_addr=8'h00, reg_wdata=8'h00, reg_we=0, busy=0, counters=0 and synchronizers=1.
REQ-029 Reset mid-transaction SHALL release SDA within one cycle, and the block SHALL then ignore the bus until the next START.

Verification
REQ-030 Write test: START, 0x72, 0x15, 0xA5, STOP -> three ACKs, one reg_we with reg_addr=0x15 and reg_wdata=0xA5, reg_addr=0x16 afterwards, busy=0 after STOP.
REQ-031 Burst test: START, 0x72, 0xFE, 0x11, 0x22, 0x33 -> reg_we at addresses 0xFE, 0xFF, 0x00 (wrap) with data 0x11, 0x22, 0x33.
REQ-032 Read test: set pointer 0x40, repeated START, 0x73, master ACK then NACK, with reg_rdata=0x3C then 0xC3 -> SDA bits 0x3C then 0xC3, state IGNORE after NACK.
REQ-033 Mismatch test: START, 0x74, 0x15, 0x99 -> SDA never driven low, no reg_we, busy stays 0.
REQ-034 Abort test: STOP after 4 data bits -> no reg_we; RST pulsed during an ACK -> SDA=z on the next cycle, reg_addr=0x00.
REQ-035 Clock ratio test: CLK_SYS/SCL = 10 and 100 -> identical received bytes and ACK timing relative to SCL edges.
